// File: rtl/pipelined_multiplier_hs.sv
// Fully pipelined A_W x B_W multiplier with valid/ready handshakes and per-operation
// signed/unsigned mode. Each stage adds one B_W/STAGES-bit slice of b; the pipeline stalls globally.
module pipelined_multiplier_hs #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic               in_sgn,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [A_W+B_W-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int P = A_W + B_W;
  localparam int S = B_W / STAGES;

  logic [P-1:0]   sum_q [STAGES];
  logic [A_W-1:0] a_q   [STAGES];
  logic [B_W-1:0] b_q   [STAGES];
  logic           sgn_q [STAGES];
  logic           vld_q [STAGES];

  logic [P-1:0]   sum_in [STAGES];
  logic [A_W-1:0] a_in   [STAGES];
  logic [B_W-1:0] b_in   [STAGES];
  logic           sgn_in [STAGES];
  logic           vld_in [STAGES];

  logic [P-1:0]   a_ext [STAGES];
  logic [P-1:0]   s_ext [STAGES];
  logic [P-1:0]   sum_d [STAGES];
  logic [B_W-1:0] b_d   [STAGES];

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage inputs: stage 0 takes the ports, later stages take the previous stage register.
  always_comb begin
    sum_in[0] = '0;
    a_in[0]   = a;
    b_in[0]   = b;
    sgn_in[0] = in_sgn;
    vld_in[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      sum_in[i] = sum_q[i-1];
      a_in[i]   = a_q[i-1];
      b_in[i]   = b_q[i-1];
      sgn_in[i] = sgn_q[i-1];
      vld_in[i] = vld_q[i-1];
    end
  end

  // The most significant slice carries negative weight for signed operations, so it is
  // sign-extended there; all arithmetic wraps modulo 2^P, which yields the exact product.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      a_ext[i] = {{B_W{sgn_in[i] & a_in[i][A_W-1]}}, a_in[i]};
      s_ext[i] = {{(P-S){sgn_in[i] & (i == STAGES - 1) & b_in[i][S-1]}}, b_in[i][S-1:0]};
      sum_d[i] = sum_in[i] + ((a_ext[i] * s_ext[i]) << (i * S));
      b_d[i]   = b_in[i] >> S;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sgn_q[i] <= 1'b0;
        vld_q[i] <= 1'b0;
      end
      out       <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= sum_d[i];
        a_q[i]   <= a_in[i];
        b_q[i]   <= b_d[i];
        sgn_q[i] <= sgn_in[i];
        vld_q[i] <= vld_in[i];
      end
      out_valid <= vld_q[STAGES-1];
      if (vld_q[STAGES-1]) begin
        out <= sum_q[STAGES-1];
      end
    end
  end

endmodule
